counter_sched: RTL and testbench

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched_pkg.sv | 13 +
 rtl/counter_sched_rr.sv | 31 +++
 rtl/counter_sched.sv | 118 +++++++++++
 tb/tb_counter_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM encoding and default sizing.
package counter_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/counter_sched_rr.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] pos;

    // First asserted request at or after ptr wins.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                win[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shared counter handed out to NREQ requesters in round-robin order; each
// grant counts 0..len and ends with a one-cycle done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; arbitrate when any req is high
//   RUN   | owner holds the counter, cnt advances toward latched len
//   DONE  | one-cycle completion pulse, pointer moves past the owner
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int CW   = CW_DEF,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]  gnt,
    output logic [CW-1:0]    cnt,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    done_id
);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, own_idx, win_idx;
    logic [CW-1:0]   own_len, win_len;
    logic [NREQ-1:0] win;
    logic            take, owner_req, at_end;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + IW'(1);
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req (req),
        .ptr (ptr),
        .win (win),
        .idx (win_idx)
    );

    assign take      = (state == IDLE) && (|req);
    assign owner_req = req[own_idx];
    assign at_end    = (cnt == own_len);

    // Pick the winner's len slice with constant indices only.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) win_len = len[i*CW +: CW];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state; a dropped owner request wins over completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take) state_nxt = RUN;
            RUN: begin
                if (!owner_req)  state_nxt = IDLE;
                else if (at_end) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner latch, counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            own_idx <= '0;
            own_len <= '0;
            cnt     <= '0;
        end else begin
            if (take) begin
                own_idx <= win_idx;
                own_len <= win_len;
                cnt     <= '0;
            end else if (state == RUN && state_nxt == RUN) begin
                cnt <= cnt + CW'(1);
            end
            if (state == DONE || (state == RUN && !owner_req))
                ptr <= ptr_after(own_idx);
        end
    end

    // Outputs decoded from registered state and owner.
    always_comb begin
        gnt     = '0;
        busy    = 1'b0;
        done    = 1'b0;
        done_id = '0;
        case (state)
            RUN: begin
                gnt[own_idx] = 1'b1;
                busy         = 1'b1;
            end
            DONE: begin
                gnt[own_idx] = 1'b1;
                busy         = 1'b1;
                done         = 1'b1;
                done_id      = own_idx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: drives on negedge, checks on negedge.
module tb_counter_sched;

    localparam int NREQ = 4;
    localparam int CW   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*CW-1:0] len = '0;
    logic [NREQ-1:0]   gnt;
    logic [CW-1:0]     cnt;
    logic              busy;
    logic              done;
    logic [1:0]        done_id;

    int n_pass  = 0;
    int n_total = 0;

    counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .cnt     (cnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    // gnt must always be one-hot or zero.
    always @(negedge clk) begin
        if (rst) begin
            n_total++;
            assert ($onehot0(gnt)) n_pass++;
            else $display("FAIL gnt_onehot: got %b want one-hot or zero", gnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic set_len(input int i, input logic [CW-1:0] v);
        len[i*CW +: CW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; len = '0;
        @(negedge clk);
        n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (cnt !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (done_id !== 2'd0) $display("FAIL reset_done_id: got %0d want 0", done_id); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_single();
        set_len(0, 3'd3); req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0001 || cnt !== CW'(k) || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL single_run k=%0d: got gnt=%b cnt=%0d busy=%b done=%b want gnt=0001 cnt=%0d busy=1 done=0",
                         k, gnt, cnt, busy, done, k);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || done_id !== 2'd0 || cnt !== 3'd3)
            $display("FAIL single_done: got done=%b id=%0d cnt=%0d want done=1 id=0 cnt=3", done, done_id, cnt);
        else n_pass++;
        req = '0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0)
            $display("FAIL single_idle: got busy=%b gnt=%b done=%b want 0 0000 0", busy, gnt, done);
        else n_pass++;
    endtask

    task automatic test_boundary();
        set_len(0, 3'd0); req = 4'b0001;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0001 || cnt !== 3'd0 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL len0_run: got gnt=%b cnt=%0d busy=%b done=%b want 0001 0 1 0", gnt, cnt, busy, done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || done_id !== 2'd0 || cnt !== 3'd0)
            $display("FAIL len0_done: got done=%b id=%0d cnt=%0d want 1 0 0", done, done_id, cnt);
        else n_pass++;
        req = '0;
        @(negedge clk);
        set_len(2, 3'd7); req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0100 || cnt !== CW'(k) || done !== 1'b0)
                $display("FAIL len7_run k=%0d: got gnt=%b cnt=%0d done=%b want 0100 %0d 0", k, gnt, cnt, done, k);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || done_id !== 2'd2 || cnt !== 3'd7)
            $display("FAIL len7_done: got done=%b id=%0d cnt=%0d want 1 2 7", done, done_id, cnt);
        else n_pass++;
        req = '0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || cnt !== 3'd7)
            $display("FAIL len7_nowrap: got busy=%b cnt=%0d want 0 7", busy, cnt);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_len(i, 3'd1);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'(1 << (g % 4));
            @(negedge clk);
            n_total++;
            if (gnt !== exp_gnt || cnt !== 3'd0 || busy !== 1'b1)
                $display("FAIL cont_run0 g=%0d: got gnt=%b cnt=%0d busy=%b want %b 0 1", g, gnt, cnt, busy, exp_gnt);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (gnt !== exp_gnt || cnt !== 3'd1 || done !== 1'b0)
                $display("FAIL cont_run1 g=%0d: got gnt=%b cnt=%0d done=%b want %b 1 0", g, gnt, cnt, done, exp_gnt);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (done !== 1'b1 || done_id !== 2'(g % 4) || gnt !== exp_gnt)
                $display("FAIL cont_done g=%0d: got done=%b id=%0d gnt=%b want 1 %0d %b", g, done, done_id, gnt, g % 4, exp_gnt);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL cont_idle g=%0d: got gnt=%b busy=%b done=%b want 0000 0 0", g, gnt, busy, done);
            else n_pass++;
            if (g == 4) req = '0;
        end
    endtask

    task automatic test_abandon();
        set_len(0, 3'd0); set_len(1, 3'd5); set_len(2, 3'd0);
        req = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0010 || cnt !== CW'(k))
                $display("FAIL abandon_run k=%0d: got gnt=%b cnt=%0d want 0010 %0d", k, gnt, cnt, k);
            else n_pass++;
        end
        req = 4'b0101;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abandon_idle: got gnt=%b busy=%b done=%b want 0000 0 0", gnt, busy, done);
        else n_pass++;
        req = 4'b0111;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0100 || cnt !== 3'd0)
            $display("FAIL abandon_next: got gnt=%b cnt=%0d want 0100 0", gnt, cnt);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || done_id !== 2'd2)
            $display("FAIL abandon_next_done: got done=%b id=%0d want 1 2", done, done_id);
        else n_pass++;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        set_len(3, 3'd6); set_len(0, 3'd0);
        req = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b1000 || cnt !== CW'(k))
                $display("FAIL areset_run k=%0d: got gnt=%b cnt=%0d want 1000 %0d", k, gnt, cnt, k);
            else n_pass++;
        end
        #1 rst = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0000 || cnt !== 3'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL areset_now: got gnt=%b cnt=%0d busy=%b done=%b want 0000 0 0 0", gnt, cnt, busy, done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0001 || cnt !== 3'd0)
            $display("FAIL areset_restart: got gnt=%b cnt=%0d want 0001 0", gnt, cnt);
        else n_pass++;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL areset_idle: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_len_stability();
        logic [CW-1:0] jitter [4];
        jitter = '{3'd0, 3'd7, 3'd1, 3'd2};
        set_len(1, 3'd3);
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0010 || cnt !== CW'(k) || done !== 1'b0)
                $display("FAIL stab_run k=%0d: got gnt=%b cnt=%0d done=%b want 0010 %0d 0", k, gnt, cnt, done, k);
            else n_pass++;
            set_len(1, jitter[k]);
        end
        @(negedge clk);
        n_total++;
        if (done !== 1'b1 || done_id !== 2'd1 || cnt !== 3'd3)
            $display("FAIL stab_done: got done=%b id=%0d cnt=%0d want 1 1 3", done, done_id, cnt);
        else n_pass++;
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_contention();
        test_abandon();
        test_async_reset();
        test_len_stability();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
